cache_port_arb: RTL

Arbiter and sequencer for the single state/tag/data array port of the L2 cache memory. It decides, one access at a time, whether the L1-side request path (cdreq) or the snoop-side request path (sureq) owns the array port. This removes the fixed "L1 before snoop" update ordering in the cache array. It sits between the inbound handshake logic and the array update logic, and holds the winning request's index and op stable until the array reports completion.

---
 rtl/cache_port_arb.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/cache_port_arb.sv
`default_nettype none
// ============================================================================
// Module      : cache_port_arb
// Description : Arbiter/sequencer for the single L2 state/tag/data array
//               port. Chooses between the L1-side request path and the
//               snoop-side request path one access at a time, and holds the
//               winner's op/address stable until the array reports done.
//               Snoops win ties by default. Optional starvation guard,
//               enabled by defining CACHE_ARB_STARVE_EN, lets a waiting L1
//               request win after STARVE_MAX back-to-back snoop grants.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_port_arb #(
    parameter int SADDR_WIDTH = 58,
    parameter int IDX_WIDTH   = 10,
    parameter int STARVE_MAX  = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             l1_valid,
    input  logic [2:0]                       l1_op,
    input  logic [SADDR_WIDTH-1:0]           l1_addr,
    output logic                             l1_ready,
    input  logic                             snp_valid,
    input  logic [1:0]                       snp_op,
    input  logic [SADDR_WIDTH-1:0]           snp_addr,
    output logic                             snp_ready,
    output logic                             arr_valid,
    output logic                             arr_sel,
    output logic [2:0]                       arr_op,
    output logic [SADDR_WIDTH-1:0]           arr_addr,
    output logic [IDX_WIDTH-1:0]             arr_idx,
    input  logic                             arr_done,
    output logic [$clog2(STARVE_MAX+1)-1:0]  starve_cnt
);

    localparam int CNT_WIDTH = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_L1   = 2'd1,
        ARB_SNP  = 2'd2
    } arb_state_t;

    arb_state_t             state_q,     state_d;
    logic                   l1_ready_q,  l1_ready_d;
    logic                   snp_ready_q, snp_ready_d;
    logic                   arr_valid_q, arr_valid_d;
    logic                   arr_sel_q,   arr_sel_d;
    logic [2:0]             arr_op_q,    arr_op_d;
    logic [SADDR_WIDTH-1:0] arr_addr_q,  arr_addr_d;

    logic                   is_idle;
    logic                   starve_ovr;
    logic                   grant_snp;
    logic                   grant_l1;

    // Grants are only ever decided while the port is free; a saturated
    // starvation count flips the tie in favour of the waiting L1 request.
    assign is_idle   = (state_q == ARB_IDLE);
    assign grant_snp = is_idle && snp_valid && !(l1_valid && starve_ovr);
    assign grant_l1  = is_idle && l1_valid && !grant_snp;

`ifdef CACHE_ARB_STARVE_EN
    localparam logic [CNT_WIDTH-1:0] STARVE_LIMIT = CNT_WIDTH'(STARVE_MAX);

    logic [CNT_WIDTH-1:0] starve_q, starve_d;

    assign starve_ovr = (starve_q == STARVE_LIMIT);
    assign starve_cnt = starve_q;

    // Count snoop grants that bypass a waiting L1 request; saturate at the limit.
    always_comb begin
        starve_d = starve_q;
        if (is_idle) begin
            if (grant_l1 || !l1_valid) begin
                starve_d = '0;
            end else if (grant_snp && (starve_q != STARVE_LIMIT)) begin
                starve_d = starve_q + 1'b1;
            end
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign starve_ovr = 1'b0;
    assign starve_cnt = '0;
`endif

    // Next-state and next-output logic: capture the winner on grant, pulse
    // its ready once, and hold everything until the array signals done.
    always_comb begin
        state_d     = state_q;
        l1_ready_d  = 1'b0;
        snp_ready_d = 1'b0;
        arr_valid_d = arr_valid_q;
        arr_sel_d   = arr_sel_q;
        arr_op_d    = arr_op_q;
        arr_addr_d  = arr_addr_q;
        case (state_q)
            ARB_IDLE: begin
                if (grant_snp) begin
                    state_d     = ARB_SNP;
                    snp_ready_d = 1'b1;
                    arr_valid_d = 1'b1;
                    arr_sel_d   = 1'b1;
                    arr_op_d    = {1'b0, snp_op};
                    arr_addr_d  = snp_addr;
                end else if (grant_l1) begin
                    state_d     = ARB_L1;
                    l1_ready_d  = 1'b1;
                    arr_valid_d = 1'b1;
                    arr_sel_d   = 1'b0;
                    arr_op_d    = l1_op;
                    arr_addr_d  = l1_addr;
                end else begin
                    arr_valid_d = 1'b0;
                end
            end
            ARB_L1, ARB_SNP: begin
                if (arr_done) begin
                    state_d     = ARB_IDLE;
                    arr_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = ARB_IDLE;
                arr_valid_d = 1'b0;
            end
        endcase
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB_IDLE;
            l1_ready_q  <= 1'b0;
            snp_ready_q <= 1'b0;
            arr_valid_q <= 1'b0;
            arr_sel_q   <= 1'b0;
            arr_op_q    <= 3'd0;
            arr_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            l1_ready_q  <= l1_ready_d;
            snp_ready_q <= snp_ready_d;
            arr_valid_q <= arr_valid_d;
            arr_sel_q   <= arr_sel_d;
            arr_op_q    <= arr_op_d;
            arr_addr_q  <= arr_addr_d;
        end
    end

    assign l1_ready  = l1_ready_q;
    assign snp_ready = snp_ready_q;
    assign arr_valid = arr_valid_q;
    assign arr_sel   = arr_sel_q;
    assign arr_op    = arr_op_q;
    assign arr_addr  = arr_addr_q;
    assign arr_idx   = arr_addr_q[IDX_WIDTH-1:0];

endmodule
`default_nettype wire
